// File: rtl/sys_cmd_ctrl_if.sv
// Signal bundle between the command controller and its RX sync, RegFile, ALU and TX FIFO neighbours.
// master = controller side, slave = surrounding blocks.
interface sys_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUNC_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [DATA_WIDTH-1:0]   RdData;
    logic                    RdData_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VALID;
    logic                    FIFO_FULL;
    logic [ADDR_WIDTH-1:0]   Address;
    logic                    WrEn;
    logic                    RdEn;
    logic [DATA_WIDTH-1:0]   WrData;
    logic                    ALU_EN;
    logic [FUNC_WIDTH-1:0]   ALU_FUNC;
    logic                    CLK_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    FRAME_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
        output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUNC, CLK_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
        input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUNC, CLK_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
    );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// REF_CLK-domain command controller: parses RX frames and sequences RegFile, ALU and TX FIFO.
// Optional inter-byte frame timeout enabled by defining SYS_CTRL_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for an opcode byte (AA/BB/CC/DD), others ignored
// WR_ADDR  | RF write: waiting for address byte
// WR_DATA  | RF write: waiting for data byte, then WrEn
// RD_ADDR  | RF read: waiting for address byte, then RdEn
// RD_WAIT  | RF read: waiting for RdData_Valid
// ALU_A    | ALU: waiting for operand A (written to RF[0])
// ALU_B    | ALU: waiting for operand B (written to RF[1])
// ALU_FN   | ALU: waiting for function byte, then ALU_EN
// ALU_WAIT | ALU: waiting for ALU_OUT_VALID
// TX_RD    | pushing read data to TX FIFO
// TX_LO    | pushing ALU result low byte
// TX_HI    | pushing ALU result high byte
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUNC_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           CLK,
    input  logic           RST,
    sys_cmd_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FN, ALU_WAIT, TX_RD, TX_LO, TX_HI
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

    state_t                  state;
    logic [2*DATA_WIDTH-1:0] tx_buf;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] timer;
    logic            in_frame;

    assign in_frame = state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN};
`else
    assign bus.FRAME_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            tx_buf        <= '0;
            bus.Address   <= '0;
            bus.WrEn      <= 1'b0;
            bus.RdEn      <= 1'b0;
            bus.WrData    <= '0;
            bus.ALU_EN    <= 1'b0;
            bus.ALU_FUNC  <= '0;
            bus.CLK_EN    <= 1'b0;
            bus.TX_P_DATA <= '0;
            bus.TX_D_VLD  <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
            bus.FRAME_ERR <= 1'b0;
            timer         <= TO_LOAD;
`endif
        end else begin
            bus.WrEn     <= 1'b0;
            bus.RdEn     <= 1'b0;
            bus.ALU_EN   <= 1'b0;
            bus.TX_D_VLD <= 1'b0;
            case (state)
                IDLE: if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == OP_WR)          state <= WR_ADDR;
                    else if (bus.RX_P_DATA == OP_RD)     state <= RD_ADDR;
                    else if (bus.RX_P_DATA == OP_ALU)    state <= ALU_A;
                    else if (bus.RX_P_DATA == OP_ALU_NO) state <= ALU_FN;
                end
                WR_ADDR: if (bus.RX_D_VLD) begin
                    bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state       <= WR_DATA;
                end
                WR_DATA: if (bus.RX_D_VLD) begin
                    bus.WrData <= bus.RX_P_DATA;
                    bus.WrEn   <= 1'b1;
                    state      <= IDLE;
                end
                RD_ADDR: if (bus.RX_D_VLD) begin
                    bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    bus.RdEn    <= 1'b1;
                    state       <= RD_WAIT;
                end
                RD_WAIT: if (bus.RdData_Valid) begin
                    tx_buf <= {{DATA_WIDTH{1'b0}}, bus.RdData};
                    state  <= TX_RD;
                end
                // Operands land in RF[0]/RF[1] where the ALU reads them.
                ALU_A: if (bus.RX_D_VLD) begin
                    bus.Address <= '0;
                    bus.WrData  <= bus.RX_P_DATA;
                    bus.WrEn    <= 1'b1;
                    state       <= ALU_B;
                end
                ALU_B: if (bus.RX_D_VLD) begin
                    bus.Address <= ADDR_WIDTH'(1);
                    bus.WrData  <= bus.RX_P_DATA;
                    bus.WrEn    <= 1'b1;
                    state       <= ALU_FN;
                end
                ALU_FN: if (bus.RX_D_VLD) begin
                    bus.ALU_FUNC <= bus.RX_P_DATA[FUNC_WIDTH-1:0];
                    bus.ALU_EN   <= 1'b1;
                    bus.CLK_EN   <= 1'b1;
                    state        <= ALU_WAIT;
                end
                ALU_WAIT: if (bus.ALU_OUT_VALID) begin
                    tx_buf     <= bus.ALU_OUT;
                    bus.CLK_EN <= 1'b0;
                    state      <= TX_LO;
                end
                TX_RD, TX_LO: if (!bus.FIFO_FULL) begin
                    bus.TX_P_DATA <= tx_buf[DATA_WIDTH-1:0];
                    bus.TX_D_VLD  <= 1'b1;
                    state         <= (state == TX_LO) ? TX_HI : IDLE;
                end
                TX_HI: if (!bus.FIFO_FULL) begin
                    bus.TX_P_DATA <= tx_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                    bus.TX_D_VLD  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef SYS_CTRL_TIMEOUT_EN
            // Down-counter reloads on every accepted byte; terminal count aborts the frame.
            bus.FRAME_ERR <= 1'b0;
            if (!in_frame || bus.RX_D_VLD) begin
                timer <= TO_LOAD;
            end else if (timer == '0) begin
                state         <= IDLE;
                bus.FRAME_ERR <= 1'b1;
                timer         <= TO_LOAD;
            end else begin
                timer <= timer - 1'b1;
            end
`endif
        end
    end
endmodule
